// File: rtl/led_blink_arbiter_if.sv
// Request/grant/LED bundle between the status sources and led_blink_arbiter.
// The master side drives the requests; the arbiter attaches to the slave side.
interface led_blink_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned BLINK_W = 4,
  parameter int unsigned DIV_W   = 32
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*BLINK_W-1:0] req_blinks;
  logic [DIV_W-1:0]         half_period;
  logic [N_REQ-1:0]         grant;
  logic                     busy;
  logic                     done;
  logic                     led;

  modport master (
    output req, req_blinks, half_period,
    input  grant, busy, done, led
  );

  modport slave (
    input  req, req_blinks, half_period,
    output grant, busy, done, led
  );
endinterface

// File: rtl/led_blink_arbiter.sv
// Round-robin, non-preemptive owner of the board LED; plays B blinks of H-cycle half-period per grant.
// Define LED_HEARTBEAT_EN to toggle the LED every HB_DIV cycles while idle.
module led_blink_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned BLINK_W = 4,
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned HB_DIV  = 1000
) (
  input logic                clk,
  input logic                rst_n,
  led_blink_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               led_q, led_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   h_q, h_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
`ifdef LED_HEARTBEAT_EN
  logic [31:0]        hb_q, hb_d;
`endif

  logic               found;
  logic [PtrW-1:0]    winner;
  logic [PtrW-1:0]    cand;
  logic [BLINK_W-1:0] b_sel;
  logic [DIV_W-1:0]   h_sel;

  // First set request at or above the pointer, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % N_REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == PtrW'(i)) b_sel = bus.req_blinks[i*BLINK_W +: BLINK_W];
    end
    h_sel = (bus.half_period == '0) ? DIV_W'(1) : bus.half_period;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    led_d   = led_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    blink_d = blink_q;
`ifdef LED_HEARTBEAT_EN
    hb_d    = '0;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef LED_HEARTBEAT_EN
        if (hb_q == HB_DIV - 1) begin
          hb_d  = '0;
          led_d = ~led_q;
        end else begin
          hb_d  = hb_q + 32'd1;
        end
`else
        led_d = 1'b0;
`endif
        if (found) begin
          grant_d = '0;
          grant_d[winner] = 1'b1;
          busy_d  = 1'b1;
          ptr_d   = (winner == PtrW'(N_REQ - 1)) ? '0 : winner + PtrW'(1);
          h_d     = h_sel;
          blink_d = b_sel;
          if (b_sel != '0) begin
            led_d   = 1'b1;
            cnt_d   = h_sel - DIV_W'(1);
            state_d = StOn;
          end else begin
            // No blinks: a single-cycle gap so the owner still sees a grant.
            led_d   = 1'b0;
            cnt_d   = '0;
            state_d = StGap;
          end
        end
      end

      StOn: begin
        if (cnt_q == '0) begin
          led_d   = 1'b0;
          cnt_d   = h_q - DIV_W'(1);
          state_d = StOff;
        end else begin
          cnt_d   = cnt_q - DIV_W'(1);
        end
      end

      StOff: begin
        if (cnt_q == '0) begin
          blink_d = blink_q - BLINK_W'(1);
          cnt_d   = h_q - DIV_W'(1);
          if (blink_q != BLINK_W'(1)) begin
            led_d   = 1'b1;
            state_d = StOn;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      StGap: begin
        if (cnt_q == '0) begin
          grant_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          led_d   = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      h_q     <= '0;
      blink_q <= '0;
`ifdef LED_HEARTBEAT_EN
      hb_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      blink_q <= blink_d;
`ifdef LED_HEARTBEAT_EN
      hb_q    <= hb_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.led   = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Self-checking bench for led_blink_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a grant-position reference model.
module tb_led_blink_arbiter;

  localparam int unsigned NReq   = 4;
  localparam int unsigned BlinkW = 4;
  localparam int unsigned DivW   = 32;
  localparam int unsigned HbDiv  = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  led_blink_arbiter_if #(.N_REQ(NReq), .BLINK_W(BlinkW), .DIV_W(DivW)) bus ();

  led_blink_arbiter #(
    .N_REQ  (NReq),
    .BLINK_W(BlinkW),
    .DIV_W  (DivW),
    .HB_DIV (HbDiv)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [6:0] dut_vec;
  assign dut_vec = {bus.grant, bus.busy, bus.done, bus.led};

  // Reference model: position within the current grant, not a phase machine.
  bit          m_busy, m_done;
  int unsigned m_owner, m_pos, m_len, m_b, m_h, m_ptr, m_idle;

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_owner = 0; m_pos = 0; m_len = 0;
    m_b = 0; m_h = 1; m_ptr = 0; m_idle = 0;
  endfunction

  function automatic void model_advance();
    logic [15:0] tmp;
    int unsigned w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (m_busy) begin
      if (m_pos == m_len - 1) begin
        m_busy = 0; m_done = 1; m_idle = 0;
      end else begin
        m_pos++;
      end
    end else if (bus.req != '0) begin
      w = m_ptr;
      for (int k = 0; k < NReq; k++) begin
        w = (m_ptr + k) % NReq;
        if (bus.req[w]) break;
      end
      tmp     = 16'(bus.req_blinks >> (w * BlinkW));
      m_b     = 32'(tmp[3:0]);
      m_h     = (bus.half_period == '0) ? 1 : bus.half_period;
      m_len   = (m_b == 0) ? 1 : 2 * m_b * m_h + m_h;
      m_owner = w; m_pos = 0; m_busy = 1;
      m_ptr   = (w + 1) % NReq;
    end else begin
      m_idle++;
    end
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [3:0] g;
    logic       l;
    g = m_busy ? 4'(1 << m_owner) : 4'b0;
    if (m_busy) l = (m_pos < 2 * m_b * m_h) && (((m_pos / m_h) % 2) == 0);
`ifdef LED_HEARTBEAT_EN
    else        l = ((m_idle / HbDiv) % 2) == 1;
`else
    else        l = 1'b0;
`endif
    return {g, m_busy, m_done, l};
  endfunction

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.req = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_blinks = '0; bus.half_period = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (dut_vec !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b want 0000000", dut_vec);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle c%0d: got %b want %b", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_single_grant();
    logic [14:0] led_pat;
    led_pat = 15'b111000111000000;
    bus.half_period = 3; bus.req_blinks = 16'h0002; bus.req = 4'b0001;
    tick();
    bus.req = '0;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      checks++;
      if (dut_vec !== exp_vec() || bus.grant !== 4'b0001 || bus.led !== led_pat[14-c]) begin
        errors++;
        $display("FAIL single c%0d: got %b want %b (led_pat %b)", c, dut_vec, exp_vec(),
                 led_pat[14-c]);
      end
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec() || bus.done !== 1'b1 || bus.grant !== 4'b0) begin
      errors++;
      $display("FAIL single_done: got %b want %b", dut_vec, exp_vec());
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: done got %b want 0", bus.done);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want [5];
    logic [3:0] got  [$];
    logic [3:0] prev;
    int         len;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    bus.req = 4'b1111; bus.req_blinks = 16'h1111; bus.half_period = 1;
    prev = '0; len = 0;
    for (int c = 0; c < 21; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rr c%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      if (bus.grant != '0 && prev == '0) got.push_back(bus.grant);
      if (bus.grant != '0) len++;
      if (bus.grant == '0 && prev != '0) begin
        checks++;
        if (len != 3 || bus.done !== 1'b1) begin
          errors++;
          $display("FAIL rr_len: got len %0d done %b want 3 and 1", len, bus.done);
        end
        len = 0;
      end
      prev = bus.grant;
    end
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== want[i]) begin
        errors++;
        $display("FAIL rr_order %0d: got %b want %b", i, (i < got.size()) ? got[i] : 4'bx,
                 want[i]);
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_zero_blinks();
    bus.req_blinks = 16'h5055; bus.half_period = 2; bus.req = 4'b0100;
    tick();
    bus.req = '0;
    checks++;
    if (dut_vec !== exp_vec() || bus.grant !== 4'b0100 || bus.led !== 1'b0) begin
      errors++;
      $display("FAIL zero_blinks_grant: got %b want %b", dut_vec, exp_vec());
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec() || bus.grant !== 4'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL zero_blinks_done: got %b want %b", dut_vec, exp_vec());
    end
    tick();
  endtask

  task automatic test_half_period_zero();
    int len;
    bus.half_period = 0; bus.req_blinks = 16'h1111; bus.req = 4'b0001;
    len = 0;
    tick();
    bus.req = '0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL hp0 c%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      if (bus.grant != '0) len++;
      tick();
    end
    checks++;
    if (len != 3) begin
      errors++;
      $display("FAIL hp0_len: got %0d want 3", len);
    end
  endtask

  task automatic test_reset_mid();
    bus.half_period = 3; bus.req_blinks = 16'h2002; bus.req = 4'b0001;
    tick();
    bus.req = '0;
    for (int c = 0; c < 7; c++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.led !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %b want 0000000", dut_vec);
    end
    tick();
    rst_n = 1'b1;
    model_reset();
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    checks++;
    if (bus.grant !== 4'b1000 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_regrant: got %b want %b", dut_vec, exp_vec());
    end
    for (int c = 0; c < 18; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_tail c%0d: got %b want %b", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_non_preempt();
    int len;
    bus.half_period = 3; bus.req_blinks = 16'h0002; bus.req = 4'b0001;
    len = 0;
    for (int c = 0; c < 22; c++) begin
      tick();
      if (c == 3) begin
        bus.req = '0; bus.half_period = 7; bus.req_blinks = 16'hFFFF;
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL nonpre c%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      if (bus.grant != '0) len++;
    end
    checks++;
    if (len != 15) begin
      errors++;
      $display("FAIL nonpre_len: got %0d want 15", len);
    end
  endtask

  task automatic test_idle_led();
    apply_reset();
    for (int c = 0; c < 45; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL idle_led c%0d: got %b want %b", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.req = '0;
      bus.req_blinks  = 16'($urandom);
      bus.half_period = $urandom_range(0, 4);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random c%0d: got %b want %b", c, dut_vec, exp_vec());
      end
    end
    bus.req = '0;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_zero_blinks();
    test_half_period_zero();
    test_reset_mid();
    test_non_preempt();
    test_idle_led();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
